// File: rtl/inst_rom_loader_if.sv
// Byte-stream / ROM-write bundle between the boot loader and its surroundings.
// master: the byte source plus ROM/CPU side; slave: the loader itself.
interface inst_rom_loader_if;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        we;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output load_start, rx_valid, rx_data,
        input  we, w_addr, w_data, cpu_hold, busy, done, err
    );

    modport slave (
        input  load_start, rx_valid, rx_data,
        output we, w_addr, w_data, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Boot loader for the instruction ROM: a 4-byte little-endian word count followed by
// that many little-endian words, each written to the ROM at consecutive word addresses.
// The CPU is held in reset while a load runs or after a failed one.
module inst_rom_loader #(
    parameter int unsigned ROM_NUM     = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input logic              i_Clk,
    input logic              i_reset,
    inst_rom_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [31:0] ROM_NUM_W = 32'(ROM_NUM);
    localparam logic [31:0] TMO_W     = 32'(TIMEOUT_CYC);

    logic [2:0]  state_q,    state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q,     word_d;      // low three bytes of the word being assembled
    logic [31:0] rem_q,      rem_d;       // words still to be written in this load
    logic [31:0] addr_q,     addr_d;      // address of the next word to write
    logic [31:0] tmo_q,      tmo_d;
    logic        we_q,       we_d;
    logic [31:0] w_addr_q,   w_addr_d;
    logic [31:0] w_data_q,   w_data_d;
    logic        hold_q,     hold_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;
    logic [31:0] full_s;                  // complete word when the 4th byte is on the bus

    assign full_s = {bus.rx_data, word_q};

    // Next-state logic: byte assembly, length check, word writes and the inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                // A strobe coinciding with the start pulse is deliberately dropped.
                if (bus.load_start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    word_d     = 24'h00_0000;
                    rem_d      = 32'd0;
                    addr_d     = BASE_ADDR;
                    tmo_d      = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN, S_DATA: begin
                if ((state_q == S_DATA) && (rem_q == 32'd0)) begin
                    // Final write is on the bus this cycle; any byte arriving now is ignored.
                    state_d = S_DONE;
                end else if (bus.rx_valid) begin
                    tmo_d = 32'd0;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        if (state_q == S_LEN) begin
                            if ((full_s == 32'd0) || (full_s > ROM_NUM_W)) begin
                                state_d = S_ERR;
                            end else begin
                                state_d = S_DATA;
                                rem_d   = full_s;
                            end
                        end else begin
                            we_d     = 1'b1;
                            w_addr_d = addr_q;
                            w_data_d = full_s;
                            addr_d   = addr_q + 32'd4;
                            rem_d    = rem_q - 32'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    word_d[7:0]   = bus.rx_data;
                            2'd1:    word_d[15:8]  = bus.rx_data;
                            2'd2:    word_d[23:16] = bus.rx_data;
                            default: word_d        = word_q;
                        endcase
                    end
                end else if ((tmo_q + 32'd1) == TMO_W) begin
                    // Any partially assembled word is abandoned.
                    state_d    = S_ERR;
                    byte_cnt_d = 2'd0;
                    tmo_d      = 32'd0;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the state being entered.
        hold_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_ERR);
        busy_d = (state_d == S_LEN) || (state_d == S_DATA);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'h00_0000;
            rem_q      <= 32'd0;
            addr_q     <= 32'd0;
            tmo_q      <= 32'd0;
            we_q       <= 1'b0;
            w_addr_q   <= 32'd0;
            w_data_q   <= 32'd0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.we       = we_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;
    assign bus.cpu_hold = hold_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed + randomized bench for inst_rom_loader. Expected ROM writes are derived from
// the words the bench sends (address = BASE + 4*index) and compared with a write log.
module tb_inst_rom_loader;

    localparam int          TMO  = 64;
    localparam int          ROMN = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic rst;
    inst_rom_loader_if intf();

    inst_rom_loader #(
        .ROM_NUM    (ROMN),
        .BASE_ADDR  (BASE),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_Clk  (clk),
        .i_reset(rst),
        .bus    (intf)
    );

    int n_checks = 0;
    int n_err    = 0;
    int double_we = 0;
    int long_done = 0;
    logic prev_we   = 1'b0;
    logic prev_done = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and pulse-shape monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (intf.we) obs_q.push_back({intf.w_addr, intf.w_data});
        if (intf.we && prev_we) double_we <= double_we + 1;
        if (intf.done && prev_done) long_done <= long_done + 1;
        prev_we   <= intf.we;
        prev_done <= intf.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        intf.rx_valid = 1'b1;
        intf.rx_data  = b;
        tick();
        intf.rx_valid = 1'b0;
        intf.rx_data  = 8'($urandom);
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] sh;
            sh = w >> (8 * i);
            send_byte(sh[7:0], (last && i == 3) ? 0 : int'($urandom_range(0, 2)));
        end
    endtask

    task automatic pulse_start();
        intf.load_start = 1'b1;
        tick();
        intf.load_start = 1'b0;
    endtask

    // Sends n random words as words idx0.. of the current load and records the expected writes.
    task automatic send_data(input int idx0, input int n, input bit ends_load);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = $urandom;
            exp_q.push_back({BASE + 32'(4 * (idx0 + i)), w});
            send_word(w, ends_load && (i == n - 1));
        end
    endtask

    task automatic wait_done(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (intf.done) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_hold_at_done"}, 64'(intf.cpu_hold), 64'd0);
        tick();
        chk({tag, "_done_one_cycle"}, 64'(intf.done), 64'd0);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        intf.load_start = 1'b0;
        intf.rx_valid   = 1'b0;
        intf.rx_data    = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_we",   64'(intf.we),       64'd0);
        chk("rst_addr", 64'(intf.w_addr),   64'd0);
        chk("rst_data", 64'(intf.w_data),   64'd0);
        chk("rst_hold", 64'(intf.cpu_hold), 64'd0);
        chk("rst_busy", 64'(intf.busy),     64'd0);
        chk("rst_done", 64'(intf.done),     64'd0);
        chk("rst_err",  64'(intf.err),      64'd0);

        // 1: two-word program
        pulse_start();
        chk("t1_busy", 64'(intf.busy),     64'd1);
        chk("t1_hold", 64'(intf.cpu_hold), 64'd1);
        send_word(32'd2, 1'b0);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b1);
        chk("t1_we_after_byte4", 64'(intf.we),       64'd1);
        chk("t1_hold_on_we",     64'(intf.cpu_hold), 64'd1);
        tick();
        chk("t1_done", 64'(intf.done), 64'd1);
        chk("t1_hold_drop", 64'(intf.cpu_hold), 64'd0);
        tick();
        chk("t1_done_one_cycle", 64'(intf.done), 64'd0);
        check_writes("t1");

        // 2: zero length, then recovery
        pulse_start();
        send_word(32'd0, 1'b1);
        tick();
        chk("t2_err",  64'(intf.err),      64'd1);
        chk("t2_hold", 64'(intf.cpu_hold), 64'd1);
        chk("t2_busy", 64'(intf.busy),     64'd0);
        pulse_start();
        chk("t2_err_cleared", 64'(intf.err), 64'd0);
        send_word(32'd1, 1'b0);
        send_data(0, 1, 1'b1);
        wait_done("t2");
        check_writes("t2");

        // 3: length limits
        pulse_start();
        send_word(32'(ROMN + 1), 1'b1);
        tick();
        chk("t3_err_over", 64'(intf.err), 64'd1);
        check_writes("t3_over");
        pulse_start();
        send_word(32'(ROMN), 1'b0);
        send_data(0, ROMN, 1'b1);
        chk("t3_last_addr", 64'(intf.w_addr), 64'(BASE + 32'(4 * (ROMN - 1))));
        wait_done("t3");
        check_writes("t3_full");

        // 4: timeout in the middle of a word
        pulse_start();
        send_word(32'd1, 1'b0);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t4_err_early", 64'(intf.err), 64'd0);
        tick();
        chk("t4_err_at_limit", 64'(intf.err),      64'd1);
        chk("t4_hold",         64'(intf.cpu_hold), 64'd1);
        check_writes("t4");

        // 5: reset mid-load
        pulse_start();
        send_word(32'd3, 1'b0);
        send_data(0, 1, 1'b1);
        send_byte(8'($urandom), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_we",   64'(intf.we),       64'd0);
        chk("t5_addr", 64'(intf.w_addr),   64'd0);
        chk("t5_data", 64'(intf.w_data),   64'd0);
        chk("t5_hold", 64'(intf.cpu_hold), 64'd0);
        chk("t5_busy", 64'(intf.busy),     64'd0);
        chk("t5_done", 64'(intf.done),     64'd0);
        chk("t5_err",  64'(intf.err),      64'd0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        tick();
        check_writes("t5");

        // 6: stray start pulses and idle bytes
        intf.rx_valid = 1'b1;
        intf.rx_data  = 8'h55;
        pulse_start();
        intf.rx_valid = 1'b0;
        send_word(32'd3, 1'b0);
        send_data(0, 1, 1'b0);
        pulse_start();
        chk("t6_busy_after_stray_start", 64'(intf.busy), 64'd1);
        send_data(1, 2, 1'b1);
        wait_done("t6");
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1);
        check_writes("t6");

        chk("we_never_back_to_back", 64'(double_we), 64'd0);
        chk("done_single_cycle",     64'(long_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
